instr_fetch_responder: RTL and testbench

//  Responder end of the instruction-fetch interface: accepts fetch addresses from the

---
 rtl/instr_fetch_responder.sv | 104 ++++++++++
 tb/tb_instr_fetch_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_responder.sv
// Instruction-fetch responder: word-addressed store behind a fixed-latency read pipeline
// and an in-order response FIFO with flush, back-pressure and a store load port.
module instr_fetch_responder #(
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int AW         = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic          flush,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic [31:0]   rsp_addr,
  output logic          rsp_err,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   store      [MEM_DEPTH];
  logic          pipe_valid [MEM_LATENCY];
  logic [31:0]   pipe_addr  [MEM_LATENCY];
  logic          pipe_err   [MEM_LATENCY];
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_addr  [FIFO_DEPTH];
  logic          fifo_err   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count, occupancy;
  logic          accept, pop, push, req_err, last_err;
  logic [31:0]   last_addr, push_instr;

  assign req_err    = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
  assign rsp_valid  = (fifo_count != '0);
  assign pop        = rsp_valid & rsp_ready & ~flush;
  // A same-cycle pop frees a slot, so a full responder can still accept while draining.
  assign req_ready  = reset_n & ~flush & ~load_en & ((occupancy < CW'(FIFO_DEPTH)) | pop);
  assign accept     = req_valid & req_ready;

  assign push       = pipe_valid[MEM_LATENCY-1];
  assign last_addr  = pipe_addr[MEM_LATENCY-1];
  assign last_err   = pipe_err[MEM_LATENCY-1];
  assign push_instr = last_err ? NOP : store[last_addr[AW+1:2]];

  assign rsp_instr  = fifo_instr[rd_ptr];
  assign rsp_addr   = fifo_addr[rd_ptr];
  assign rsp_err    = fifo_err[rd_ptr];

  always_ff @(posedge clk) begin
    if (load_en) store[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_addr[i]  <= '0;
        pipe_err[i]   <= 1'b0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_addr[i]  <= '0;
        fifo_err[i]   <= 1'b0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      occupancy  <= '0;
    end else if (flush) begin
      for (int i = 0; i < MEM_LATENCY; i++) pipe_valid[i] <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      occupancy  <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_addr[0]  <= req_addr;
      pipe_err[0]   <= req_err;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
      if (push) begin
        fifo_instr[wr_ptr] <= push_instr;
        fifo_addr[wr_ptr]  <= last_addr;
        fifo_err[wr_ptr]   <= last_err;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      occupancy  <= occupancy + CW'(accept) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed
// scenarios with literal expectations and a randomized stall run.
module tb_instr_fetch_responder;

  localparam int MEM_DEPTH   = 256;
  localparam int MEM_LATENCY = 2;
  localparam int FIFO_DEPTH  = 4;

  logic        clk = 1'b0, reset_n = 1'b0, req_valid = 1'b0, flush = 1'b0;
  logic        rsp_ready = 1'b0, load_en = 1'b0;
  logic [31:0] req_addr = '0, load_data = '0;
  logic [7:0]  load_addr = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_instr, rsp_addr;

  int tests = 0, fails = 0;

  typedef struct { int avail; logic [31:0] addr; logic [31:0] instr; logic err; } ent_t;
  typedef struct { logic [31:0] addr; logic [31:0] instr; logic err; } rsp_t;
  ent_t        mq[$];
  rsp_t        got_q[$];
  logic [31:0] model_mem [MEM_DEPTH];
  int          edge_no = 0;
  int          acc_cnt = 0, first_acc = -1, first_vld = -1, last_vld = -1;

  instr_fetch_responder #(
    .MEM_DEPTH(MEM_DEPTH), .MEM_LATENCY(MEM_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_addr(rsp_addr), .rsp_err(rsp_err), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  // Reference: every accepted fetch becomes visible MEM_LATENCY edges later, in order.
  function automatic logic model_valid();
    return (mq.size() > 0) && (mq[0].avail <= edge_no);
  endfunction

  function automatic logic model_ready(input logic p);
    return reset_n && !flush && !load_en && ((mq.size() < FIFO_DEPTH) || p);
  endfunction

  function automatic ent_t model_fetch(input logic [31:0] a, input int avail);
    ent_t e;
    e.avail = avail;
    e.addr  = a;
    e.err   = (a[1:0] != 2'b00) || (a >= 32'(4 * MEM_DEPTH));
    e.instr = e.err ? 32'h0000_0013 : model_mem[a[9:2]];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic rr,
                               input logic fl, input logic le, input logic [7:0] la,
                               input logic [31:0] ld);
    req_valid = v;  req_addr = a;  rsp_ready = rr;  flush = fl;
    load_en = le;   load_addr = la;  load_data = ld;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin : model_update
    logic v, p, r;
    v = model_valid();
    p = v && rsp_ready;
    r = model_ready(p);
    if (load_en) model_mem[load_addr] <= load_data;
    if (!reset_n || flush) mq.delete();
    else begin
      if (p) void'(mq.pop_front());
      if (req_valid && r) mq.push_back(model_fetch(req_addr, edge_no + 1 + MEM_LATENCY));
    end
    edge_no <= edge_no + 1;
  end

  always @(negedge clk) begin : compare
    logic ev;
    ev = model_valid();
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(ev));
    checkOutput("req_ready", 32'(req_ready), 32'(model_ready(ev && rsp_ready)));
    if (ev) begin
      checkOutput("rsp_addr", rsp_addr, mq[0].addr);
      checkOutput("rsp_instr", rsp_instr, mq[0].instr);
      checkOutput("rsp_err", 32'(rsp_err), 32'(mq[0].err));
    end
  end

  always @(negedge clk) begin : monitor
    if (req_valid && req_ready) begin
      acc_cnt++;
      if (first_acc < 0) first_acc = edge_no + 1;
    end
    if (rsp_valid) begin
      if (first_vld < 0) first_vld = edge_no;
      last_vld = edge_no;
    end
    if (reset_n && !flush && rsp_valid && rsp_ready)
      got_q.push_back(rsp_t'{rsp_addr, rsp_instr, rsp_err});
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int acc0, cyc, r;
    logic [31:0] a;
    logic v, rr;

    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset rsp_instr", rsp_instr, 0);
    checkOutput("reset rsp_addr", rsp_addr, 0);
    checkOutput("reset rsp_err", 32'(rsp_err), 0);
    checkOutput("reset req_ready", 32'(req_ready), 0);
    reset_n = 1'b1;

    // Stream four fetches back to back.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 8'(i), 32'((i + 1) * 11));
    first_acc = -1; first_vld = -1; got_q.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'(i * 4), 1, 0, 0, 0, 0);
    repeat (6) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("t1 count", 32'(got_q.size()), 4);
    checkOutput("t1 latency", 32'(first_vld - first_acc), 2);
    checkOutput("t1 back-to-back", 32'(last_vld - first_vld), 3);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checkOutput("t1 instr", got_q[i].instr, 32'((i + 1) * 11));
      checkOutput("t1 addr", got_q[i].addr, 32'(i * 4));
    end

    // Fill with the consumer stalled, then drain.
    got_q.delete(); acc0 = acc_cnt;
    for (int i = 0; i < 8; i++) applyStimulus(1, 32'((i % 4) * 4), 0, 0, 0, 0, 0);
    checkOutput("t2 accepted", 32'(acc_cnt - acc0), 4);
    checkOutput("t2 full ready", 32'(req_ready), 0);
    repeat (8) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("t2 count", 32'(got_q.size()), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      checkOutput("t2 instr", got_q[i].instr, 32'((i + 1) * 11));

    // Misaligned and out-of-range fetches.
    got_q.delete();
    applyStimulus(1, 32'h2, 1, 0, 0, 0, 0);
    applyStimulus(1, 32'h400, 1, 0, 0, 0, 0);
    applyStimulus(1, 32'h4, 1, 0, 0, 0, 0);
    repeat (6) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("t3 count", 32'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      checkOutput("t3 err0", 32'(got_q[0].err), 1);
      checkOutput("t3 instr0", got_q[0].instr, 32'h13);
      checkOutput("t3 addr0", got_q[0].addr, 32'h2);
      checkOutput("t3 err1", 32'(got_q[1].err), 1);
      checkOutput("t3 instr1", got_q[1].instr, 32'h13);
      checkOutput("t3 addr1", got_q[1].addr, 32'h400);
      checkOutput("t3 err2", 32'(got_q[2].err), 0);
      checkOutput("t3 instr2", got_q[2].instr, 32'd22);
    end

    // Flush discards everything outstanding.
    got_q.delete(); acc0 = acc_cnt;
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'(i * 4), 0, 0, 0, 0, 0);
    checkOutput("t4 accepted", 32'(acc_cnt - acc0), 3);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("t4 valid after flush", 32'(rsp_valid), 0);
    applyStimulus(1, 32'hC, 1, 0, 0, 0, 0);
    repeat (6) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("t4 count", 32'(got_q.size()), 1);
    if (got_q.size() == 1) checkOutput("t4 instr", got_q[0].instr, 32'd44);

    // Reset with entries outstanding; store survives.
    got_q.delete();
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'(i * 4), 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("t5 ready in reset", 32'(req_ready), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    checkOutput("t5 rsp_valid", 32'(rsp_valid), 0);
    checkOutput("t5 rsp_instr", rsp_instr, 0);
    checkOutput("t5 rsp_addr", rsp_addr, 0);
    checkOutput("t5 rsp_err", 32'(rsp_err), 0);
    applyStimulus(1, 32'h0, 1, 0, 0, 0, 0);
    repeat (6) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("t5 count", 32'(got_q.size()), 1);
    if (got_q.size() == 1) checkOutput("t5 instr", got_q[0].instr, 32'd11);

    // Randomized valid/ready stalls against the model.
    for (int i = 0; i < MEM_DEPTH; i++) applyStimulus(0, 0, 0, 0, 1, 8'(i), $urandom);
    got_q.delete(); acc0 = acc_cnt; cyc = 0;
    while ((acc_cnt - acc0) < 1000 && cyc < 20000) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0:       a = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
        1:       a = $urandom | 32'h400;
        default: a = $urandom_range(0, 255) << 2;
      endcase
      v  = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 9) < 6);
      applyStimulus(v, a, rr, 0, 0, 0, 0);
      cyc++;
    end
    repeat (10) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("t6 accepted", 32'(acc_cnt - acc0), 1000);
    checkOutput("t6 returned", 32'(got_q.size()), 1000);
    checkOutput("t6 model drained", 32'(mq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
